// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
// Covers the jump-source selector encodings and the controller state type.
package pc_pkg;

    localparam logic [1:0] JP_RELATIVE   = 2'd0;
    localparam logic [1:0] JP_TO_F       = 2'd1;
    localparam logic [1:0] JP_TO_F_EXACT = 2'd2;
    localparam logic [1:0] JP_RSVD       = 2'd3;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_state_t;

endpackage

// File: rtl/pc_gen_target_calc.sv
// Combinational redirect-target calculation.
// Produces the raw jump target, its alignment check and the target to load once a trap is folded in.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               IALIGN      = 4,
    parameter logic [XLEN-1:0]  TRAP_VECTOR = 32'h100
) (
    input  logic [XLEN-1:0] inst_addr,
    input  logic [1:0]      jump_sel,
    input  logic [XLEN-1:0] f_data,
    input  logic [XLEN-1:0] rel_addr,
    output logic [XLEN-1:0] target,
    output logic            target_valid,
    output logic            misalign,
    output logic [XLEN-1:0] eff_target
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    always_comb begin
        target       = '0;
        target_valid = 1'b1;
        case (jump_sel)
            JP_RELATIVE:   target = inst_addr + rel_addr;
            JP_TO_F:       target = {f_data[XLEN-1:1], 1'b0};
            JP_TO_F_EXACT: target = f_data;
            default:       target_valid = 1'b0;
        endcase
    end

    assign misalign   = (target & ALIGN_MASK) != '0;
    assign eff_target = misalign ? TRAP_VECTOR : target;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential stepping, relative/register/trap redirects,
// stall-latched redirects, halt/resume control and misaligned-target trapping.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h100,
    parameter int               IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go_next,
    input  logic            jump,
    input  logic [1:0]      jump_sel,
    input  logic [XLEN-1:0] f_data,
    input  logic [XLEN-1:0] rel_addr,
    input  logic            trap,
    input  logic            halt,
    input  logic            resume,
    output logic [XLEN-1:0] inst_addr,
    output logic            pc_valid,
    output logic            jump_pending,
    output logic            misalign,
    output logic [XLEN-1:0] fault_addr
);

    if (!(IALIGN == 2 || IALIGN == 4)) begin : g_bad_ialign
        $error("pc_gen: IALIGN must be 2 or 4");
    end

    pc_state_t       state_reg, state_next;
    logic [XLEN-1:0] addr_reg, addr_next;
    logic            pend_reg, pend_next;
    logic [XLEN-1:0] pend_target_reg, pend_target_next;
    logic            pend_mis_reg, pend_mis_next;
    logic            misalign_reg, misalign_next;
    logic [XLEN-1:0] fault_reg, fault_next;

    logic [XLEN-1:0] calc_target;
    logic            calc_valid;
    logic            calc_mis;
    logic [XLEN-1:0] calc_eff;
    logic            jump_ok;

    pc_target_calc #(
        .XLEN        (XLEN),
        .IALIGN      (IALIGN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_calc (
        .inst_addr    (addr_reg),
        .jump_sel     (jump_sel),
        .f_data       (f_data),
        .rel_addr     (rel_addr),
        .target       (calc_target),
        .target_valid (calc_valid),
        .misalign     (calc_mis),
        .eff_target   (calc_eff)
    );

    // Reserved selector encodings are dropped as if no jump had been requested.
    assign jump_ok = jump && calc_valid;

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        pend_next        = pend_reg;
        pend_target_next = pend_target_reg;
        pend_mis_next    = pend_mis_reg;
        misalign_next    = 1'b0;
        fault_next       = fault_reg;
        case (state_reg)
            BOOT: state_next = RUN;
            RUN: begin
                if (trap) begin
                    addr_next = TRAP_VECTOR;
                    pend_next = 1'b0;
                end else if (halt) begin
                    state_next = HALT;
                end else if (go_next && jump_ok) begin
                    addr_next     = calc_eff;
                    misalign_next = calc_mis;
                    if (calc_mis) fault_next = calc_target;
                    pend_next     = 1'b0;
                end else if (go_next && pend_reg) begin
                    // Alignment was judged when latched; apply that verdict now.
                    addr_next     = pend_mis_reg ? TRAP_VECTOR : pend_target_reg;
                    misalign_next = pend_mis_reg;
                    if (pend_mis_reg) fault_next = pend_target_reg;
                    pend_next     = 1'b0;
                end else if (go_next) begin
                    addr_next = addr_reg + XLEN'(IALIGN);
                end else if (jump_ok) begin
                    pend_next        = 1'b1;
                    pend_target_next = calc_target;
                    pend_mis_next    = calc_mis;
                end
            end
            HALT: begin
                if (trap) begin
                    addr_next  = TRAP_VECTOR;
                    pend_next  = 1'b0;
                    state_next = RUN;
                end else begin
                    if (jump_ok) begin
                        pend_next        = 1'b1;
                        pend_target_next = calc_target;
                        pend_mis_next    = calc_mis;
                    end
                    if (resume) state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= BOOT;
            addr_reg        <= RESET_VECTOR;
            pend_reg        <= 1'b0;
            pend_target_reg <= '0;
            pend_mis_reg    <= 1'b0;
            misalign_reg    <= 1'b0;
            fault_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            pend_reg        <= pend_next;
            pend_target_reg <= pend_target_next;
            pend_mis_reg    <= pend_mis_next;
            misalign_reg    <= misalign_next;
            fault_reg       <= fault_next;
        end
    end

    assign inst_addr    = addr_reg;
    assign pc_valid     = (state_reg == RUN);
    assign jump_pending = pend_reg;
    assign misalign     = misalign_reg;
    assign fault_addr   = fault_reg;

endmodule
